// File: rtl/vid_pkg.sv
// Shared definitions for the video output stage: default raster timing,
// the packed pixel type and the saturating 9-bit increment used by both axes.
package vid_pkg;

  localparam int unsigned H_START_DEF  = 16;
  localparam int unsigned H_ACTIVE_DEF = 256;
  localparam int unsigned V_START_DEF  = 3;
  localparam int unsigned V_ACTIVE_DEF = 240;

  localparam logic [8:0] AXIS_MAX     = 9'd511;
  localparam logic [8:0] AXIS_NEAR_MAX = 9'd510;

  typedef logic [23:0] rgb_t;

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    logic [8:0] r;
    if (v == AXIS_MAX) begin
      r = AXIS_MAX;
    end else begin
      r = v + 9'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vid_axis_ctr.sv
// One raster axis: 9-bit counter with load-to-zero, saturating increment and
// a 10-bit window compare so a window ending at 512 does not wrap.
module vid_axis_ctr
  import vid_pkg::*;
#(
  parameter int unsigned WIN_START = H_START_DEF,
  parameter int unsigned WIN_LEN   = H_ACTIVE_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic       load_i,
  input  logic       inc_i,
  output logic [8:0] cnt_o,
  output logic       in_win_o
);

  localparam int unsigned WIN_END = WIN_START + WIN_LEN;
  localparam logic [9:0]  WIN_LO  = WIN_START[9:0];
  localparam logic [9:0]  WIN_HI  = WIN_END[9:0];

  logic [8:0] cnt_q;
  logic [8:0] cnt_d;

  // load beats increment so a frame restart lands exactly on zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 9'd0;
    end else if (inc_i) begin
      cnt_d = sat_inc9(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 9'd0;
    end else if (ce_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign in_win_o = ({1'b0, cnt_q} >= WIN_LO) && ({1'b0, cnt_q} < WIN_HI);

endmodule

// File: rtl/vid_out.sv
// Video output timing stage: rebuilds sync levels from upstream edge events,
// tracks X/Y, derives blanking/DE and gates the pixel bus, all on PCE.
module vid_out
  import vid_pkg::*;
#(
  parameter int unsigned H_START  = H_START_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_START  = V_START_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        PCE,
  input  logic        HSYNC_POSEDGE,
  input  logic        HSYNC_NEGEDGE,
  input  logic        VSYNC_POSEDGE,
  input  logic        VSYNC_NEGEDGE,
  input  logic [23:0] RGB_IN,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        HBLANK,
  output logic        VBLANK,
  output logic        DE,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [8:0]  X,
  output logic [8:0]  Y,
  output logic [8:0]  LINE_LEN,
  output logic        FIELD,
  output logic        SYNC_ERR
);

  logic [8:0] x_s;
  logic [8:0] y_s;
  logic       x_win_s;
  logic       y_win_s;
  logic       h_fault_s;

  logic       hsync_q,    hsync_d;
  logic       vsync_q,    vsync_d;
  logic       hblank_q,   hblank_d;
  logic       vblank_q,   vblank_d;
  logic       de_q,       de_d;
  rgb_t       rgb_q,      rgb_d;
  logic [8:0] line_len_q, line_len_d;
  logic       field_q,    field_d;
  logic       sync_err_q, sync_err_d;

  vid_axis_ctr #(
    .WIN_START (H_START),
    .WIN_LEN   (H_ACTIVE)
  ) u_x_ctr (
    .clk_i    (CLK),
    .rst_i    (RES),
    .ce_i     (PCE),
    .load_i   (HSYNC_NEGEDGE),
    .inc_i    (1'b1),
    .cnt_o    (x_s),
    .in_win_o (x_win_s)
  );

  vid_axis_ctr #(
    .WIN_START (V_START),
    .WIN_LEN   (V_ACTIVE)
  ) u_y_ctr (
    .clk_i    (CLK),
    .rst_i    (RES),
    .ce_i     (PCE),
    .load_i   (VSYNC_NEGEDGE),
    .inc_i    (HSYNC_NEGEDGE),
    .cnt_o    (y_s),
    .in_win_o (y_win_s)
  );

  // Out-of-order hsync edges, or a line so long that X is about to pin at 511
  assign h_fault_s = (HSYNC_POSEDGE & hsync_q)
                   | (HSYNC_NEGEDGE & ~hsync_q)
                   | (HSYNC_POSEDGE & HSYNC_NEGEDGE)
                   | (~HSYNC_NEGEDGE & (x_s >= AXIS_NEAR_MAX));

  always_comb begin
    hsync_d = hsync_q;
    if (HSYNC_NEGEDGE) begin
      hsync_d = 1'b0;
    end else if (HSYNC_POSEDGE) begin
      hsync_d = 1'b1;
    end else begin
      hsync_d = hsync_q;
    end

    vsync_d = vsync_q;
    if (VSYNC_NEGEDGE) begin
      vsync_d = 1'b0;
    end else if (VSYNC_POSEDGE) begin
      vsync_d = 1'b1;
    end else begin
      vsync_d = vsync_q;
    end

    line_len_d = line_len_q;
    if (HSYNC_NEGEDGE) begin
      line_len_d = sat_inc9(x_s);
    end else begin
      line_len_d = line_len_q;
    end

    field_d = field_q;
    if (VSYNC_POSEDGE) begin
      field_d = ~field_q;
    end else begin
      field_d = field_q;
    end

    sync_err_d = sync_err_q | h_fault_s;

    // pixel pipeline is one PCE deep, aligned with the blanking flags
    hblank_d = ~x_win_s;
    vblank_d = ~y_win_s;
    de_d     = x_win_s & y_win_s;
    rgb_d    = 24'h000000;
    if (de_d) begin
      rgb_d = RGB_IN;
    end else begin
      rgb_d = 24'h000000;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
      de_q       <= 1'b0;
      rgb_q      <= 24'h000000;
      line_len_q <= 9'd0;
      field_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else if (PCE) begin
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      de_q       <= de_d;
      rgb_q      <= rgb_d;
      line_len_q <= line_len_d;
      field_q    <= field_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign HSYNC    = hsync_q;
  assign VSYNC    = vsync_q;
  assign HBLANK   = hblank_q;
  assign VBLANK   = vblank_q;
  assign DE       = de_q;
  assign R        = rgb_q[23:16];
  assign G        = rgb_q[15:8];
  assign B        = rgb_q[7:0];
  assign X        = x_s;
  assign Y        = y_s;
  assign LINE_LEN = line_len_q;
  assign FIELD    = field_q;
  assign SYNC_ERR = sync_err_q;

endmodule

// File: tb/tb_vid_out.sv
// Directed bench for vid_out: reset values, PCE hold, sync faults, saturation,
// mid-line reset, vsync/hsync collision and one nominal 318x264 frame.
module tb_vid_out;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        PCE = 1'b0;
  logic        HSYNC_POSEDGE = 1'b0;
  logic        HSYNC_NEGEDGE = 1'b0;
  logic        VSYNC_POSEDGE = 1'b0;
  logic        VSYNC_NEGEDGE = 1'b0;
  logic [23:0] RGB_IN = 24'h000000;
  logic        HSYNC, VSYNC, HBLANK, VBLANK, DE, FIELD, SYNC_ERR;
  logic [7:0]  R, G, B;
  logic [8:0]  X, Y, LINE_LEN;

  int tests_run    = 0;
  int tests_failed = 0;

  vid_out dut (
    .CLK (CLK), .RES (RES), .PCE (PCE),
    .HSYNC_POSEDGE (HSYNC_POSEDGE), .HSYNC_NEGEDGE (HSYNC_NEGEDGE),
    .VSYNC_POSEDGE (VSYNC_POSEDGE), .VSYNC_NEGEDGE (VSYNC_NEGEDGE),
    .RGB_IN (RGB_IN), .HSYNC (HSYNC), .VSYNC (VSYNC),
    .HBLANK (HBLANK), .VBLANK (VBLANK), .DE (DE),
    .R (R), .G (G), .B (B), .X (X), .Y (Y),
    .LINE_LEN (LINE_LEN), .FIELD (FIELD), .SYNC_ERR (SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one CLK cycle with the given PCE/event pattern; returns 1ns after the edge
  task automatic drive(input logic pce, input logic hp, input logic hn,
                       input logic vp, input logic vn, input logic [23:0] rgb);
    PCE = pce; HSYNC_POSEDGE = hp; HSYNC_NEGEDGE = hn;
    VSYNC_POSEDGE = vp; VSYNC_NEGEDGE = vn; RGB_IN = rgb;
    @(posedge CLK); #1;
    PCE = 1'b0; HSYNC_POSEDGE = 1'b0; HSYNC_NEGEDGE = 1'b0;
    VSYNC_POSEDGE = 1'b0; VSYNC_NEGEDGE = 1'b0;
  endtask

  task automatic step(input logic hp, input logic hn, input logic vp,
                      input logic vn, input logic [23:0] rgb);
    drive(1'b1, hp, hn, vp, vn, rgb);
  endtask

  // reset edge with PCE and competing events asserted, which reset must override
  task automatic do_reset();
    RES = 1'b1; PCE = 1'b1; HSYNC_NEGEDGE = 1'b1; VSYNC_POSEDGE = 1'b1;
    @(posedge CLK); #1;
    RES = 1'b0; PCE = 1'b0; HSYNC_NEGEDGE = 1'b0; VSYNC_POSEDGE = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_hsync"},    HSYNC,     1'b0);
    check({pfx, "_vsync"},    VSYNC,     1'b0);
    check({pfx, "_hblank"},   HBLANK,    1'b1);
    check({pfx, "_vblank"},   VBLANK,    1'b1);
    check({pfx, "_de"},       DE,        1'b0);
    check({pfx, "_rgb"},      {R, G, B}, 24'h000000);
    check({pfx, "_x"},        X,         9'd0);
    check({pfx, "_y"},        Y,         9'd0);
    check({pfx, "_line_len"}, LINE_LEN,  9'd0);
    check({pfx, "_field"},    FIELD,     1'b0);
    check({pfx, "_sync_err"}, SYNC_ERR,  1'b0);
  endtask

  int   x_m, y_m, de_row, de_total, active_rows, de_bad_rows;
  int   ll_bad, rgb_bad, de_mis, field_tog;
  logic act, field_prev, de_prev, rise_checked;

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    RES = 1'b0;
    check_reset_vals("rst");

    // PCE=0 cycles must not move any state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    check("x_after_3", X, 9'd3);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF);
    check("hold_x", X, 9'd3);
    check("hold_hsync", HSYNC, 1'b0);
    check("hold_vsync", VSYNC, 1'b0);
    check("hold_field", FIELD, 1'b0);

    // both hsync events together: negedge wins, fault flagged
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    check("pos_hsync", HSYNC, 1'b1);
    check("pos_x", X, 9'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'h000000);
    check("both_hsync", HSYNC, 1'b0);
    check("both_x", X, 9'd0);
    check("both_line_len", LINE_LEN, 9'd5);
    check("both_err", SYNC_ERR, 1'b1);

    // double posedge fault is sticky until reset
    do_reset();
    check("rst2_err", SYNC_ERR, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    check("dbl_first_err", SYNC_ERR, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    check("dbl_second_err", SYNC_ERR, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    check("dbl_sticky_err", SYNC_ERR, 1'b1);
    do_reset();
    check("dbl_cleared_err", SYNC_ERR, 1'b0);

    // no negedge for 600 PCEs: X pins at 511
    for (int i = 1; i <= 600; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
      if (i == 510) begin
        check("sat_x510", X, 9'd510);
        check("sat_err_at_510", SYNC_ERR, 1'b0);
      end
      if (i == 511) begin
        check("sat_x511", X, 9'd511);
        check("sat_err_at_511", SYNC_ERR, 1'b1);
      end
    end
    check("sat_x_held", X, 9'd511);
    check("sat_err_held", SYNC_ERR, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    check("sat_line_len", LINE_LEN, 9'd511);
    check("sat_x_reload", X, 9'd0);

    // reset in the middle of an active line at X=100, Y=50
    do_reset();
    repeat (50) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 24'hABCDEF);
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'hABCDEF);
    end
    check("mid_y50", Y, 9'd50);
    check("mid_err_clean", SYNC_ERR, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 24'hABCDEF);
    repeat (98) step(1'b0, 1'b0, 1'b0, 1'b0, 24'hABCDEF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'hABCDEF);
    check("mid_x100", X, 9'd100);
    check("mid_hsync", HSYNC, 1'b1);
    check("mid_vsync", VSYNC, 1'b1);
    check("mid_field", FIELD, 1'b1);
    check("mid_de", DE, 1'b1);
    check("mid_rgb", {R, G, B}, 24'hABCDEF);
    do_reset();
    check_reset_vals("midrst");
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 24'hABCDEF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'hABCDEF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'hABCDEF);
    check("resume_x", X, 9'd0);
    check("resume_y", Y, 9'd1);
    check("resume_line_len", LINE_LEN, 9'd7);
    check("resume_err", SYNC_ERR, 1'b0);

    // vsync negedge and hsync negedge on the same PCE
    repeat (2) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    end
    check("coll_pre_y", Y, 9'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 24'h000000);
    check("coll_y", Y, 9'd0);
    check("coll_x", X, 9'd0);
    check("coll_err", SYNC_ERR, 1'b0);

    // one nominal frame: 318-PCE lines, 264 lines
    do_reset();
    x_m = 0; y_m = 0; de_total = 0; active_rows = 0; de_bad_rows = 0;
    ll_bad = 0; rgb_bad = 0; de_mis = 0; field_tog = 0;
    field_prev = 1'b0; de_prev = 1'b0; rise_checked = 1'b0;
    for (int r = 0; r < 264; r++) begin
      de_row = 0;
      for (int c = 0; c < 318; c++) begin
        act = (x_m >= 16) && (x_m < 272) && (y_m >= 3) && (y_m < 243);
        step(c == 300, c == 310, (r == 256) && (c == 300), (r == 261) && (c == 310),
             act ? 24'h123456 : 24'hFFFFFF);
        if (c == 310) x_m = 0;
        else if (x_m < 511) x_m++;
        if ((r == 261) && (c == 310)) y_m = 0;
        else if ((c == 310) && (y_m < 511)) y_m++;
        if (DE !== act) de_mis++;
        if (DE === 1'b1) begin
          de_row++;
          de_total++;
          if ({R, G, B} !== 24'h123456) rgb_bad++;
        end else if ({R, G, B} !== 24'h000000) begin
          rgb_bad++;
        end
        if ((DE === 1'b1) && (de_prev === 1'b0) && !rise_checked) begin
          check("rgb_at_de_rise", {R, G, B}, 24'h123456);
          rise_checked = 1'b1;
        end
        if (FIELD !== field_prev) field_tog++;
        field_prev = FIELD;
        de_prev    = DE;
        if ((c == 310) && (r >= 1) && (LINE_LEN !== 9'd318)) ll_bad++;
        if ((c == 310) && (r == 1)) check("line_len_2nd", LINE_LEN, 9'd318);
        if ((c == 310) && (r == 261)) begin
          check("frame_vneg_y", Y, 9'd0);
          check("frame_vneg_x", X, 9'd0);
        end
      end
      if (de_row != 0) begin
        active_rows++;
        if (de_row != 256) de_bad_rows++;
      end
      if (r == 3) check("de_row3", de_row, 256);
    end
    check("line_len_bad_rows", ll_bad, 0);
    check("de_bad_rows", de_bad_rows, 0);
    check("de_active_rows", active_rows, 240);
    check("de_total", de_total, 61440);
    check("de_timing_mis", de_mis, 0);
    check("rgb_bad", rgb_bad, 0);
    check("rgb_seen_rise", rise_checked, 1'b1);
    check("field_toggles", field_tog, 1);
    check("field_end", FIELD, 1'b1);
    check("frame_err", SYNC_ERR, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
